// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit feeding the register-file write port.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish after one CALC cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RD_W-1:0]  rd_in,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [RD_W-1:0]  rd_out,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         f_q, f_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   oper_q, oper_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic [RD_W-1:0]    rd_lat_q, rd_lat_d;
  logic [RD_W-1:0]    rd_out_q, rd_out_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode at acceptance
  logic             is_div, a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             in_div0, in_ovf, in_skip;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign sa       = a_signed & op_a[WIDTH-1];
  assign sb       = b_signed & op_b[WIDTH-1];
  assign abs_a    = sa ? -op_a : op_a;
  assign abs_b    = sb ? -op_b : op_b;
  assign in_div0  = is_div && (op_b == '0);
  assign in_ovf   = is_div && ~funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign in_skip = in_div0 | in_ovf | (~is_div & ((op_a == '0) | (op_b == '0)));
`else
  assign in_skip = 1'b0;
`endif

  // One iteration: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [2*WIDTH-1:0] div_step, step;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s, r_s;
  logic [WIDTH-1:0]   fin_res;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : {(WIDTH+1){1'b0}});
  assign div_sh  = acc_q[2*WIDTH-1:WIDTH-1];

  always_comb begin
    div_step = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    if (div_sh >= {1'b0, oper_q}) begin
      div_step = {WIDTH'(div_sh - {1'b0, oper_q}), acc_q[WIDTH-2:0], 1'b1};
    end
  end

  assign step   = f_q[2] ? div_step : {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_s = neg_q ? -step : step;
  assign q_s    = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign r_s    = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_res = '0;
    case (f_q)
      3'b000:                 fin_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: begin
        if (div0_q)     fin_res = '1;
        else if (ovf_q) fin_res = {1'b1, {(WIDTH-1){1'b0}}};
        else            fin_res = q_s;
      end
      default: begin
        if (div0_q)     fin_res = a_q;
        else if (ovf_q) fin_res = '0;
        else            fin_res = r_s;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f_d      = f_q;
    a_d      = a_q;
    oper_d   = oper_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    rd_lat_d = rd_lat_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f_d      = funct3;
          a_d      = op_a;
          oper_d   = is_div ? abs_b : abs_a;
          acc_d    = in_skip ? '0 : {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          div0_d   = in_div0;
          ovf_d    = in_ovf;
          rd_lat_d = rd_in;
          cnt_d    = in_skip ? CW'(1) : CW'(WIDTH);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = fin_res;
          rd_out_d = rd_lat_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      f_q      <= '0;
      a_q      <= '0;
      oper_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      a_q      <= a_d;
      oper_q   <= oper_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      rd_lat_q <= rd_lat_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign wb_we  = done && (rd_out_q != '0);
  assign rd_out = rd_out_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against a behavioural RV32M model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_we;
  logic [4:0]  rd_out;
  logic [31:0] result;

  muldiv_unit #(.WIDTH(W), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_we(wb_we), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0] pu;
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return (a == 0) || (b == 0);
    return (b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (EARLY && is_special(f, a, b)) ? 2 : W + 1;
  endfunction

  // Transaction-level model: countdown of remaining cycles, results from ref_op
  bit          m_busy, m_done;
  int          m_left;
  logic [31:0] m_pend_res, m_result;
  logic [4:0]  m_pend_rd, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_result = '0; m_rd = '0; m_pend_res = '0; m_pend_rd = '0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_result = m_pend_res;
        m_rd = m_pend_rd;
      end
    end else if (start) begin
      m_busy = 1;
      m_left = exp_lat(funct3, op_a, op_b) - 1;
      m_pend_res = ref_op(funct3, op_a, op_b);
      m_pend_rd = rd_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("wb_we", wb_we, m_done && (m_rd != 0));
      check("rd_out", rd_out, m_rd);
      check("result", result, m_result);
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  t_f[12]   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] t_a[12]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] t_b[12]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_exp[12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};

  initial begin
    int lat;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    logic [4:0] rr;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wb_we", wb_we, 0);
    check("reset_rd_out", rd_out, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      check($sformatf("model_pin%0d", i), ref_op(t_f[i], t_a[i], t_b[i]), t_exp[i]);
      run_op(t_f[i], t_a[i], t_b[i], (i == 0) ? 5'd5 : 5'(i + 1), lat);
      check($sformatf("lat_dir%0d", i), lat, exp_lat(t_f[i], t_a[i], t_b[i]));
      check($sformatf("res_dir%0d", i), result, t_exp[i]);
      if (i == 0) begin
        check("mul_rd_out", rd_out, 5);
        check("mul_wb_we", wb_we, 1);
      end
    end

    // Second start while busy must be ignored; op_a changes after acceptance
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) op_a = 32'd555;
      if (lat == 10) begin
        start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd9;
        check("busy_during_restart", busy, 1);
      end
      if (lat == 11) begin
        start = 1'b0;
        check("busy_after_restart", busy, 1);
      end
      @(negedge clk);
      lat++;
    end
    check("ignore_lat", lat, W + 1);
    check("ignore_result", result, 14);
    check("ignore_rd_out", rd_out, 3);

    run_op(3'd0, 32'd3, 32'd3, 5'd0, lat);
    check("rd0_done", done, 1);
    check("rd0_wb_we", wb_we, 0);
    check("rd0_result", result, 9);

    // Asynchronous reset in the middle of a divide
    run_op(3'd7, 32'd100, 32'd7, 5'd4, lat);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_wb_we", wb_we, 0);
    check("midrst_result", result, 0);
    check("midrst_rd_out", rd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 5'd6, lat);
    check("post_rst_lat", lat, W + 1);
    check("post_rst_result", result, 12);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      rr = 5'($urandom);
      run_op(rf, ra, rb, rr, lat);
      check($sformatf("rand_lat%0d", i), lat, exp_lat(rf, ra, rb));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
